// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store access unit: FSM encoding,
// RV32I load/store funct3 codes and the data_mem sign_mask encodings.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // bit 3 = sign-extend, bits 2:0 = byte lanes touched
  localparam logic [3:0] MASK_LB  = 4'b1001;
  localparam logic [3:0] MASK_LH  = 4'b1011;
  localparam logic [3:0] MASK_LBU = 4'b0001;
  localparam logic [3:0] MASK_LHU = 4'b0011;
  localparam logic [3:0] MASK_SB  = 4'b0001;
  localparam logic [3:0] MASK_SH  = 4'b0011;
  localparam logic [3:0] MASK_W   = 4'b0111;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the data_mem port bundle of the access unit.
// master = pipeline + data_mem side, slave = the access unit itself.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_memwrite;
  logic              mem_memread;
  logic [3:0]        mem_sign_mask;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_clk_stall;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_read_data, mem_clk_stall,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_read_data, mem_clk_stall,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
  );

endinterface

// File: rtl/mem_access_unit_mask_decode.sv
// Combinational decode of a load/store request into the data_mem sign_mask,
// plus illegal-funct3 and misalignment flags.
module mem_mask_decode
  import mem_access_unit_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       illegal,
  output logic       misaligned
);

  always_comb begin
    sign_mask  = 4'b0000;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    sign_mask = MASK_SB;
        F3_H:    begin sign_mask = MASK_SH; misaligned = addr_lo[0]; end
        F3_W:    begin sign_mask = MASK_W;  misaligned = |addr_lo;   end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    sign_mask = MASK_LB;
        F3_BU:   sign_mask = MASK_LBU;
        F3_H:    begin sign_mask = MASK_LH;  misaligned = addr_lo[0]; end
        F3_HU:   begin sign_mask = MASK_LHU; misaligned = addr_lo[0]; end
        F3_W:    begin sign_mask = MASK_W;   misaligned = |addr_lo;   end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the pipeline and data_mem:
// IDLE -> ISSUE (one strobe cycle) -> WAIT (until stall drops or timeout) -> RESP.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]        mask_q;
  logic              we_q, err_q;

  logic [3:0]        dec_mask;
  logic              dec_illegal, dec_misaligned;
  logic              accept, bad_req, timeout;

  mem_mask_decode u_mask_decode (
    .we         (bus.req_we),
    .funct3     (bus.req_funct3),
    .addr_lo    (bus.req_addr[1:0]),
    .sign_mask  (dec_mask),
    .illegal    (dec_illegal),
    .misaligned (dec_misaligned)
  );

  assign accept  = bus.req_valid && (state == ST_IDLE);
  assign bad_req = dec_illegal || dec_misaligned;
  assign timeout = bus.mem_clk_stall && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.mem_memread    = 1'b0;
    bus.mem_memwrite   = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_err       = 1'b0;
    bus.resp_rdata     = '0;
    bus.mem_addr       = addr_q;
    bus.mem_write_data = wdata_q;
    bus.mem_sign_mask  = mask_q;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        // rejected requests skip the memory entirely and answer next cycle
        if (accept) state_nxt = bad_req ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.mem_memread  = !we_q;
        bus.mem_memwrite = we_q;
        state_nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.mem_clk_stall || timeout) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = rdata_q;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mask_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
        mask_q  <= bad_req ? 4'b0000 : dec_mask;
        err_q   <= bad_req;
        rdata_q <= '0;
      end else if (state == ST_WAIT) begin
        if (!bus.mem_clk_stall) rdata_q <= we_q ? '0 : bus.mem_read_data;
        else if (timeout)       err_q   <= 1'b1;
      end
    end
  end

endmodule
